// File: rtl/nand_wr_data.sv
// NAND page-program data-input phase: moves LEN upstream bytes onto DQ, one WEn pulse per byte.
// CLE/ALE stay low; Over pulses once when the last byte's WEn high phase completes.
module nand_wr_data #(
    parameter int unsigned tWP_cnt = 1,
    parameter int unsigned tWH_cnt = 1,
    parameter int unsigned LEN_W   = 13
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Start,
    input  logic [LEN_W-1:0] LEN,
    output logic             Over,
    input  logic [7:0]       DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             BUSY,
    output logic             CLE,
    output logic             ALE,
    output logic             WEn,
    output logic [7:0]       NAND_DQ
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = 8'hFE;
    localparam logic [CNT_W-1:0] WP_LIM  = CNT_W'(tWP_cnt);
    localparam logic [CNT_W-1:0] WH_LIM  = CNT_W'(tWH_cnt);

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        WAIT_DATA = 5'b00010,
        WE_LOW    = 5'b00100,
        WE_HIGH   = 5'b01000,
        OVER      = 5'b10000
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       data_reg;
    logic [CNT_W-1:0] wp_cnt;
    logic [CNT_W-1:0] wh_cnt;
    logic             wp_done;
    logic             wh_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

    assign wp_done   = (wp_cnt >= WP_LIM);
    assign wh_done   = (wh_cnt >= WH_LIM);
    assign DIN_READY = (state == WAIT_DATA);
    assign BUSY      = (state != IDLE);

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; any non-one-hot encoding falls back to IDLE
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = (LEN == '0) ? OVER : WAIT_DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DATA: state_nxt = DIN_VALID ? WE_LOW : WAIT_DATA;
            WE_LOW:    state_nxt = wp_done ? WE_HIGH : WE_LOW;
            WE_HIGH: begin
                if (wh_done) begin
                    state_nxt = (remaining == LEN_W'(1)) ? OVER : WAIT_DATA;
                end else begin
                    state_nxt = WE_HIGH;
                end
            end
            OVER:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Byte bookkeeping, phase counters and registered NAND pins
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            remaining <= '0;
            data_reg  <= '0;
            wp_cnt    <= '0;
            wh_cnt    <= '0;
            CLE       <= 1'b0;
            ALE       <= 1'b0;
            WEn       <= 1'b1;
            NAND_DQ   <= '0;
            Over      <= 1'b0;
        end else begin
            if ((state == IDLE) && Start && (LEN != '0)) begin
                remaining <= LEN;
            end else if ((state == WE_HIGH) && wh_done && (remaining != '0)) begin
                remaining <= remaining - LEN_W'(1);
            end

            if ((state == WAIT_DATA) && DIN_VALID) begin
                data_reg <= DIN;
            end

            wp_cnt <= (state == WE_LOW)  ? sat_inc(wp_cnt) : '0;
            wh_cnt <= (state == WE_HIGH) ? sat_inc(wh_cnt) : '0;

            CLE <= 1'b0;
            ALE <= 1'b0;
            WEn <= (state != WE_LOW);
            if ((state == WE_LOW) || (state == WE_HIGH)) begin
                NAND_DQ <= data_reg;
            end
            Over <= (state == OVER);
        end
    end

endmodule

// File: tb/tb_nand_wr_data.sv
// Scoreboard bench for nand_wr_data: two instances with different WEn timings,
// randomized byte streams and upstream stalls checked against a transfer-level model.
`timescale 1ns/1ps
module tb_nand_wr_data;

    localparam int unsigned LEN_W = 13;
    localparam int NI = 2;

    logic CLK = 1'b0;
    logic RSTn;
    always #5 CLK = ~CLK;

    logic             start     [NI];
    logic [LEN_W-1:0] len       [NI];
    logic             over      [NI];
    logic [7:0]       din       [NI];
    logic             din_valid [NI];
    logic             din_ready [NI];
    logic             busy      [NI];
    logic             cle       [NI];
    logic             ale       [NI];
    logic             wen       [NI];
    logic [7:0]       dq        [NI];

    logic [7:0] src_q     [NI][$];
    logic [7:0] exp_q     [NI][$];
    int         exp_len_q [NI][$];
    int         exp_lat_q [NI][$];
    logic [7:0] pat [$];

    bit stall     [NI];
    bit rnd_stall [NI];
    int hs_cnt    [NI] = '{0, 0};
    int start_cyc [NI] = '{0, 0};
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    nand_wr_data #(.tWP_cnt(1), .tWH_cnt(1), .LEN_W(LEN_W)) u_dut0 (
        .CLK(CLK), .RSTn(RSTn), .Start(start[0]), .LEN(len[0]), .Over(over[0]),
        .DIN(din[0]), .DIN_VALID(din_valid[0]), .DIN_READY(din_ready[0]), .BUSY(busy[0]),
        .CLE(cle[0]), .ALE(ale[0]), .WEn(wen[0]), .NAND_DQ(dq[0])
    );

    nand_wr_data #(.tWP_cnt(3), .tWH_cnt(2), .LEN_W(LEN_W)) u_dut1 (
        .CLK(CLK), .RSTn(RSTn), .Start(start[1]), .LEN(len[1]), .Over(over[1]),
        .DIN(din[1]), .DIN_VALID(din_valid[1]), .DIN_READY(din_ready[1]), .BUSY(busy[1]),
        .CLE(cle[1]), .ALE(ale[1]), .WEn(wen[1]), .NAND_DQ(dq[1])
    );

    function automatic int twp(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int twh(input int g);
        return (g == 0) ? 1 : 2;
    endfunction

    // Cycles per byte with the upstream never stalling
    function automatic int per_byte(input int g);
        return (twp(g) + 1) + (twh(g) + 1) + 1;
    endfunction

    task automatic check(input int g, input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h (t=%0t)", g, nm, act, req, $time);
        end
    endtask

    task automatic clear_q(input int g);
        src_q[g].delete();
        exp_q[g].delete();
        exp_len_q[g].delete();
        exp_lat_q[g].delete();
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int TWP = (g == 0) ? 1 : 3;
        int         low_len = 0;
        int         wr_since = 0;
        logic [7:0] pulse_dq = '0;
        logic       prev_wen = 1'b1;
        logic       prev_over = 1'b0;
        logic [7:0] e;
        int         n;
        int         lat;

        // Upstream byte source
        initial begin
            din_valid[g] = 1'b0;
            din[g] = '0;
            forever begin
                @(posedge CLK);
                #1;
                if (rnd_stall[g]) stall[g] = ($urandom_range(0, 2) == 0);
                din_valid[g] = RSTn && (src_q[g].size() > 0) && !stall[g];
                din[g] = (src_q[g].size() > 0) ? src_q[g][0] : 8'($urandom);
            end
        end

        // Monitor: handshakes, WEn pulses, latched bytes and Over
        always @(negedge CLK) begin
            if (!RSTn) begin
                low_len = 0;
                wr_since = 0;
                prev_wen = 1'b1;
                prev_over = 1'b0;
            end else begin
                if (din_valid[g] && din_ready[g]) begin
                    if (src_q[g].size() > 0) void'(src_q[g].pop_front());
                    hs_cnt[g]++;
                end
                if (wen[g] == 1'b0) begin
                    if (prev_wen) pulse_dq = dq[g];
                    else check(g, dq[g] == pulse_dq, "dq_stable_low", dq[g], pulse_dq);
                    low_len++;
                end else if (!prev_wen) begin
                    check(g, low_len == TWP + 1, "wen_low_width", low_len, TWP + 1);
                    check(g, exp_q[g].size() != 0, "unexpected_write", dq[g], 0);
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        check(g, dq[g] == e, "written_byte", dq[g], e);
                    end
                    wr_since++;
                    low_len = 0;
                end
                if (over[g]) begin
                    check(g, prev_over == 1'b0, "over_one_cycle", prev_over, 0);
                    check(g, {cle[g], ale[g]} == 2'b00, "cle_ale_low", {cle[g], ale[g]}, 0);
                    check(g, exp_len_q[g].size() != 0, "unexpected_over", 1, 0);
                    if (exp_len_q[g].size() != 0) begin
                        n = exp_len_q[g].pop_front();
                        lat = exp_lat_q[g].pop_front();
                        check(g, wr_since == n, "bytes_per_xfer", wr_since, n);
                        if (lat >= 0) check(g, cyc - start_cyc[g] == lat, "over_latency",
                                            cyc - start_cyc[g], lat);
                    end
                    wr_since = 0;
                end
                prev_wen = wen[g];
                prev_over = over[g];
            end
        end
    end

    task automatic wait_idle(input int g, input int budget);
        int t;
        t = 0;
        @(negedge CLK);
        while (!((exp_len_q[g].size() == 0) && !busy[g]) && (t < budget)) begin
            @(negedge CLK);
            t++;
        end
        check(g, t < budget, "xfer_timeout", t, budget);
        if (t >= budget) begin
            RSTn = 1'b0;
            clear_q(g);
            @(posedge CLK);
            #2 RSTn = 1'b1;
        end
    endtask

    // One transfer: n bytes, optional junk byte beyond LEN, random or directed stall, extra Start
    task automatic run_xfer(input int g, input int n, input bit extra, input bit rs,
                            input bit mstall, input int restart_len);
        int hs0;
        int t;
        int k;
        logic [7:0] b;
        logic [7:0] b0;
        hs0 = hs_cnt[g];
        b0 = '0;
        stall[g] = 1'b0;
        rnd_stall[g] = rs;
        for (int i = 0; i < n; i++) begin
            b = (i < pat.size()) ? pat[i] : 8'($urandom);
            if (i == 0) b0 = b;
            src_q[g].push_back(b);
            exp_q[g].push_back(b);
        end
        pat.delete();
        if (extra) src_q[g].push_back(8'($urandom));
        exp_len_q[g].push_back(n);
        exp_lat_q[g].push_back((rs || mstall) ? -1 : n * per_byte(g) + 1);
        @(posedge CLK);
        #1;
        start[g] = 1'b1;
        len[g] = LEN_W'(n);
        @(posedge CLK);
        #1;
        start_cyc[g] = cyc;
        start[g] = 1'b0;
        len[g] = LEN_W'($urandom);
        if (restart_len >= 0) begin
            k = $urandom_range(1, 4);
            repeat (k) @(posedge CLK);
            #1;
            if (busy[g]) begin
                start[g] = 1'b1;
                len[g] = LEN_W'(restart_len);
                @(posedge CLK);
                #1;
                start[g] = 1'b0;
            end
        end
        if (mstall) begin
            t = 0;
            while ((hs_cnt[g] == hs0) && (t < 100)) begin
                @(negedge CLK);
                t++;
            end
            stall[g] = 1'b1;
            t = 0;
            while (!din_ready[g] && (t < 100)) begin
                @(negedge CLK);
                t++;
            end
            check(g, t < 100, "stall_reach_wait", t, 100);
            repeat (7) begin
                check(g, wen[g] == 1'b1, "stall_wen_high", wen[g], 1);
                check(g, dq[g] == b0, "stall_dq_hold", dq[g], b0);
                @(negedge CLK);
            end
            stall[g] = 1'b0;
        end
        wait_idle(g, 100 + n * 60);
        rnd_stall[g] = 1'b0;
        stall[g] = 1'b0;
        check(g, hs_cnt[g] - hs0 == n, "handshake_count", hs_cnt[g] - hs0, n);
        check(g, src_q[g].size() == int'(extra), "leftover_bytes", src_q[g].size(), int'(extra));
        src_q[g].delete();
    endtask

    task automatic check_reset_values(input int g);
        check(g, wen[g] == 1'b1, "rst_wen", wen[g], 1);
        check(g, dq[g] == 8'h00, "rst_dq", dq[g], 0);
        check(g, over[g] == 1'b0, "rst_over", over[g], 0);
        check(g, din_ready[g] == 1'b0, "rst_din_ready", din_ready[g], 0);
        check(g, busy[g] == 1'b0, "rst_busy", busy[g], 0);
        check(g, {cle[g], ale[g]} == 2'b00, "rst_cle_ale", {cle[g], ale[g]}, 0);
    endtask

    // Reset asserted while WEn is low must abort the transfer at once
    task automatic reset_mid(input int g);
        int t;
        src_q[g].push_back(8'h5A);
        exp_q[g].push_back(8'h5A);
        src_q[g].push_back(8'h3C);
        exp_q[g].push_back(8'h3C);
        exp_len_q[g].push_back(2);
        exp_lat_q[g].push_back(-1);
        @(posedge CLK);
        #1;
        start[g] = 1'b1;
        len[g] = LEN_W'(2);
        @(posedge CLK);
        #1;
        start[g] = 1'b0;
        t = 0;
        while ((wen[g] != 1'b0) && (t < 50)) begin
            @(negedge CLK);
            t++;
        end
        check(g, (wen[g] == 1'b0) && busy[g], "reach_pulse", t, 50);
        @(posedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        check_reset_values(g);
        clear_q(g);
        repeat (2) @(posedge CLK);
        #2 RSTn = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        check(g, busy[g] == 1'b0, "post_rst_idle", busy[g], 0);
        check(g, wen[g] == 1'b1, "post_rst_wen", wen[g], 1);
    endtask

    initial begin
        RSTn = 1'b0;
        for (int g = 0; g < NI; g++) begin
            start[g] = 1'b0;
            len[g] = '0;
            stall[g] = 1'b0;
            rnd_stall[g] = 1'b0;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int g = 0; g < NI; g++) check_reset_values(g);
        @(posedge CLK);
        #2 RSTn = 1'b1;
        repeat (2) @(posedge CLK);

        pat = '{8'hA5};
        run_xfer(0, 1, 1'b0, 1'b0, 1'b0, -1);
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_xfer(0, 4, 1'b0, 1'b0, 1'b0, -1);
        pat = '{8'h11, 8'h22, 8'h33};
        run_xfer(0, 3, 1'b0, 1'b0, 1'b1, -1);
        run_xfer(0, 0, 1'b1, 1'b0, 1'b0, -1);
        run_xfer(0, 2, 1'b1, 1'b0, 1'b0, -1);
        pat = '{8'hC3, 8'h3C, 8'h96};
        run_xfer(1, 3, 1'b0, 1'b0, 1'b0, 7);
        run_xfer(1, 0, 1'b1, 1'b0, 1'b0, -1);
        reset_mid(0);

        for (int i = 0; i < 20; i++) begin
            for (int g = 0; g < NI; g++) begin
                run_xfer(g, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b0,
                         ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : -1);
            end
        end

        repeat (4) @(posedge CLK);
        for (int g = 0; g < NI; g++) begin
            check(g, exp_q[g].size() == 0, "unwritten_bytes", exp_q[g].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nand_wr_data.md
Name: nand_wr_data

Overview:
- Data-input phase of the NAND page-program sequence. Sits directly downstream of the address-write stage and upstream of the 0x10 confirm command.
- Takes LEN bytes from an upstream byte stream over a valid/ready handshake and drives each byte onto the NAND DQ bus with one WEn pulse. CLE and ALE stay low throughout.
- Pulse widths use the same tWP/tWH cycle-count scheme as the command and address stages.
- Raises Over for one cycle when done, so the sequencer can issue the next command.

Parameters:
- tWP_cnt, 1: WEn low-phase count; low phase lasts tWP_cnt+1 cycles.
- tWH_cnt, 1: WEn high-phase count; high phase lasts tWH_cnt+1 cycles.
- LEN_W, 13: width of the byte-count input (max 8191 bytes, covers 4320-byte page plus spare).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- Start  in  1  start request; sampled only in IDLE.
- LEN  in  LEN_W  bytes to write; latched on accepted Start.
- Over  out  1  one-cycle done pulse, registered.
- DIN  in  8  upstream data byte.
- DIN_VALID  in  1  upstream byte valid.
- DIN_READY  out  1  combinational; high only in state WAIT_DATA.
- BUSY  out  1  combinational; high when state is not IDLE.
- CLE  out  1  registered; always 0.
- ALE  out  1  registered; always 0.
- WEn  out  1  registered NAND write-enable, active low.
- NAND_DQ  out  8  registered data to the NAND IO bus.

Behaviour:
- Reset values: all registers reset asynchronously. State=IDLE; CLE=0; ALE=0; WEn=1; NAND_DQ=0; Over=0; remaining=0; data_reg=0; WP_CNT=0; WH_CNT=0. Resetting mid-transfer aborts the transfer; no partial state survives.
- State machine (one-hot, registered current state, combinational next state; undefined encodings go to IDLE):
  - IDLE: if Start=1 and LEN=0, go to OVER. If Start=1 and LEN≠0, latch remaining<=LEN and go to WAIT_DATA. Otherwise stay.
  - WAIT_DATA: DIN_READY=1. When DIN_VALID=1, latch data_reg<=DIN and go to WE_LOW. Otherwise stay indefinitely.
  - WE_LOW: go to WE_HIGH when WP_CNT>=tWP_cnt.
  - WE_HIGH: when WH_CNT>=tWH_cnt, decrement remaining. If remaining was 1, go to OVER; else go to WAIT_DATA.
  - OVER: always go to IDLE.
- Counters:
  - WP_CNT increments every cycle in WE_LOW and is 0 in any other state.
  - WH_CNT does the same for WE_HIGH.
  - Both saturate at 8'hFE.
- Outputs are registered from the current state, so they lag the state by one cycle:
  - WEn<=0 in WE_LOW, 1 in all other states.
  - NAND_DQ<=data_reg in WE_LOW and WE_HIGH; holds its value in all other states.
  - Over<=1 in OVER, 0 otherwise.
- Result: each WEn low pulse is exactly tWP_cnt+1 cycles, and DQ is stable for its full length plus the following high phase. The NAND latches data on the WEn rising edge.
- Cycles per byte with DIN_VALID held high: (tWP_cnt+1)+(tWH_cnt+1)+1.
- Start while BUSY is ignored; LEN is not re-sampled.
- DIN_VALID outside WAIT_DATA is ignored, and no byte is consumed.
- Exactly LEN handshakes occur per transfer; no byte is ever dropped or duplicated.
- remaining is LEN_W bits wide and never underflows; the LEN=0 case bypasses it.

Test Plan:
- Reset values: assert RSTn=0 mid-pulse (WEn=0, BUSY=1) -> WEn=1, NAND_DQ=0, Over=0, DIN_READY=0 immediately. After release, stays IDLE until Start.
- Single byte, tWP=tWH=1, LEN=1, DIN=8'hA5 valid: one pulse with WEn low for exactly 2 cycles, NAND_DQ=8'hA5 throughout, DIN_READY high 1 cycle, Over a 1-cycle pulse. Total Start-to-Over timing matches the cycle count above.
- Burst of 4 bytes 8'h11,22,33,44 with DIN_VALID always high: 4 WEn pulses, each byte stable on DQ during its pulse, 5 cycles per byte, Over once after the 4th rising edge of WEn.
- Upstream stall, LEN=3 with DIN_VALID dropped 7 cycles before byte 2: WEn stays 1 and NAND_DQ holds 8'h11 during the stall. Byte 2 is written after VALID returns; exactly 3 handshakes.
- LEN=0 -> no WEn pulse, DIN_READY never high, Over pulse 2 cycles after Start.
- Start pulsed again mid-transfer with a different LEN, and parameters tWP=3,tWH=2 -> extra Start ignored. WEn low 4 cycles and high 3 cycles per byte. Byte count follows the original LEN.
